// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: primary write-back, FIFO-buffered mul/div results, busy scoreboard.
// Optional WB_FORWARD_EN adds forwarding of the value currently being committed to the decode sources.
module regfile_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_pri_we,
  input  logic [AW-1:0] i_pri_wra,
  input  logic [DW-1:0] i_pri_wrd,
  input  logic          i_sec_valid,
  output logic          o_sec_ready,
  input  logic [AW-1:0] i_sec_wra,
  input  logic [DW-1:0] i_sec_wrd,
  input  logic          i_issue_valid,
  input  logic [AW-1:0] i_issue_rd,
  output logic          o_issue_ready,
  input  logic [AW-1:0] i_ra1,
  input  logic [AW-1:0] i_ra2,
  input  logic [AW-1:0] i_dst,
  output logic          o_stall,
`ifdef WB_FORWARD_EN
  output logic          o_fwd1_hit,
  output logic [DW-1:0] o_fwd1_data,
  output logic          o_fwd2_hit,
  output logic [DW-1:0] o_fwd2_data,
`endif
  output logic          o_regWe,
  output logic [AW-1:0] o_WRA,
  output logic [DW-1:0] o_WRD
);

  localparam int NR = 1 << AW;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] fifo_wra [DEPTH];
  logic [DW-1:0] fifo_wrd [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [NR-1:0] busy, busy_nxt;
  logic          src_sec;

  logic full, empty, push, pop, pri_take, busy_clr, busy_set;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign o_sec_ready = rstn && !full;
  assign push        = i_sec_valid && o_sec_ready;
  assign pri_take    = i_pri_we && (i_pri_wra != '0);
  assign pop         = !pri_take && !empty;

  // A secondary write is in flight while o_regWe is high; its busy bit drops at the commit edge.
  assign busy_clr      = o_regWe && src_sec;
  assign o_issue_ready = !busy[i_issue_rd];
  assign busy_set      = i_issue_valid && o_issue_ready && (i_issue_rd != '0);

  always_comb begin
    busy_nxt = busy;
    if (busy_clr) busy_nxt[o_WRA] = 1'b0;
    if (busy_set) busy_nxt[i_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

`ifdef WB_FORWARD_EN
  logic clr_ra1, clr_ra2;
  assign o_fwd1_hit  = o_regWe && (o_WRA == i_ra1) && (i_ra1 != '0);
  assign o_fwd2_hit  = o_regWe && (o_WRA == i_ra2) && (i_ra2 != '0);
  assign o_fwd1_data = o_WRD;
  assign o_fwd2_data = o_WRD;
  assign clr_ra1     = busy_clr && o_fwd1_hit;
  assign clr_ra2     = busy_clr && o_fwd2_hit;
  assign o_stall     = (busy[i_ra1] && !clr_ra1) || (busy[i_ra2] && !clr_ra2) || busy[i_dst];
`else
  assign o_stall     = busy[i_ra1] || busy[i_ra2] || busy[i_dst];
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      busy    <= '0;
      src_sec <= 1'b0;
      o_regWe <= 1'b0;
      o_WRA   <= '0;
      o_WRD   <= '0;
    end else begin
      if (push) begin
        fifo_wra[wr_ptr] <= i_sec_wra;
        fifo_wrd[wr_ptr] <= i_sec_wrd;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      if (pri_take) begin
        o_regWe <= 1'b1;
        o_WRA   <= i_pri_wra;
        o_WRD   <= i_pri_wrd;
        src_sec <= 1'b0;
      end else if (pop) begin
        // r0 results are consumed silently.
        o_regWe <= (fifo_wra[rd_ptr] != '0);
        o_WRA   <= fifo_wra[rd_ptr];
        o_WRD   <= fifo_wrd[rd_ptr];
        src_sec <= 1'b1;
      end else begin
        o_regWe <= 1'b0;
        src_sec <= 1'b0;
      end

      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter (DEPTH=2, AW=5, DW=32).
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_pri_we;
  logic [4:0]  i_pri_wra;
  logic [31:0] i_pri_wrd;
  logic        i_sec_valid;
  logic        o_sec_ready;
  logic [4:0]  i_sec_wra;
  logic [31:0] i_sec_wrd;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic        o_issue_ready;
  logic [4:0]  i_ra1, i_ra2, i_dst;
  logic        o_stall;
`ifdef WB_FORWARD_EN
  logic        o_fwd1_hit, o_fwd2_hit;
  logic [31:0] o_fwd1_data, o_fwd2_data;
`endif
  logic        o_regWe;
  logic [4:0]  o_WRA;
  logic [31:0] o_WRD;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .rstn(rstn),
    .i_pri_we(i_pri_we), .i_pri_wra(i_pri_wra), .i_pri_wrd(i_pri_wrd),
    .i_sec_valid(i_sec_valid), .o_sec_ready(o_sec_ready),
    .i_sec_wra(i_sec_wra), .i_sec_wrd(i_sec_wrd),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd), .o_issue_ready(o_issue_ready),
    .i_ra1(i_ra1), .i_ra2(i_ra2), .i_dst(i_dst), .o_stall(o_stall),
`ifdef WB_FORWARD_EN
    .o_fwd1_hit(o_fwd1_hit), .o_fwd1_data(o_fwd1_data),
    .o_fwd2_hit(o_fwd2_hit), .o_fwd2_data(o_fwd2_data),
`endif
    .o_regWe(o_regWe), .o_WRA(o_WRA), .o_WRD(o_WRD)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [4:0] wra, input logic [31:0] wrd);
    chk({tag, "_we"}, 32'(o_regWe), 32'(we));
    if (we) begin
      chk({tag, "_wra"}, 32'(o_WRA), 32'(wra));
      chk({tag, "_wrd"}, o_WRD, wrd);
    end
  endtask

  initial begin
    rstn = 1'b0;
    i_pri_we = 0; i_pri_wra = 0; i_pri_wrd = 0;
    i_sec_valid = 0; i_sec_wra = 0; i_sec_wrd = 0;
    i_issue_valid = 0; i_issue_rd = 0;
    i_ra1 = 0; i_ra2 = 0; i_dst = 0;

    // Reset
    step(); step();
    chk("rst_we", 32'(o_regWe), 0);
    chk("rst_wra", 32'(o_WRA), 0);
    chk("rst_wrd", o_WRD, 0);
    chk("rst_ready", 32'(o_sec_ready), 0);
    chk("rst_stall", 32'(o_stall), 0);
    rstn = 1'b1; #1;
    chk("post_rst_ready", 32'(o_sec_ready), 1);

    // Primary only
    i_pri_we = 1; i_pri_wra = 5; i_pri_wrd = 32'hA5;
    step();
    chk_wb("pri", 1, 5, 32'hA5);
    i_pri_we = 0;
    step();
    chk_wb("pri_idle", 0, 0, 0);

    // Collision: primary wins, secondary follows one cycle later
    i_pri_we = 1; i_pri_wra = 3; i_pri_wrd = 32'h11;
    i_sec_valid = 1; i_sec_wra = 7; i_sec_wrd = 32'h22;
    step();
    chk_wb("col_pri", 1, 3, 32'h11);
    i_pri_we = 0; i_sec_valid = 0;
    step();
    chk_wb("col_sec", 1, 7, 32'h22);
    step();
    chk_wb("col_idle", 0, 0, 0);

    // FIFO full under sustained primary traffic
    i_pri_we = 1; i_pri_wra = 1; i_pri_wrd = 32'h1;
    i_sec_valid = 1; i_sec_wra = 10; i_sec_wrd = 32'hA0;
    chk("full_rdy0", 32'(o_sec_ready), 1);
    step();
    i_sec_wra = 11; i_sec_wrd = 32'hB0;
    chk("full_rdy1", 32'(o_sec_ready), 1);
    step();
    chk("full_rdy2", 32'(o_sec_ready), 0);
    i_sec_wra = 12; i_sec_wrd = 32'hC0;
    step();
    chk("full_rdy3", 32'(o_sec_ready), 0);
    step();
    chk_wb("full_pri4", 1, 1, 32'h1);
    i_pri_we = 0;
    step();
    chk_wb("drain_a", 1, 10, 32'hA0);
    chk("drain_rdy", 32'(o_sec_ready), 1);
    step();
    chk_wb("drain_b", 1, 11, 32'hB0);
    i_sec_valid = 0;
    step();
    chk_wb("drain_c", 1, 12, 32'hC0);
    step();
    chk_wb("drain_idle", 0, 0, 0);

    // Scoreboard on r9
    i_issue_valid = 1; i_issue_rd = 9;
    #1;
    chk("sb_iss_rdy0", 32'(o_issue_ready), 1);
    step();
    i_issue_valid = 0; i_ra1 = 9;
    #1;
    chk("sb_stall1", 32'(o_stall), 1);
    chk("sb_iss_rdy1", 32'(o_issue_ready), 0);
    i_ra1 = 0; i_dst = 9; #1;
    chk("sb_stall_dst", 32'(o_stall), 1);
    i_dst = 0; i_ra2 = 9; #1;
    chk("sb_stall_ra2", 32'(o_stall), 1);
    i_ra2 = 0; i_ra1 = 9;
    step();
    chk("sb_stall2", 32'(o_stall), 1);
    i_sec_valid = 1; i_sec_wra = 9; i_sec_wrd = 32'h99;
    step();
    i_sec_valid = 0;
    chk("sb_stall_push", 32'(o_stall), 1);
    chk_wb("sb_push", 0, 0, 0);
    step();
    chk_wb("sb_commit", 1, 9, 32'h99);
`ifndef WB_FORWARD_EN
    chk("sb_stall_flight", 32'(o_stall), 1);
`endif
    step();
    chk("sb_stall_clr", 32'(o_stall), 0);
    chk("sb_iss_rdy2", 32'(o_issue_ready), 1);
    i_ra1 = 0;

    // r0 handling
    i_issue_valid = 1; i_issue_rd = 0; #1;
    chk("r0_iss_rdy", 32'(o_issue_ready), 1);
    i_pri_we = 1; i_pri_wra = 0; i_pri_wrd = 32'hDEAD;
    step();
    i_issue_valid = 0; i_pri_we = 0;
    chk_wb("r0_pri", 0, 0, 0);
    chk("r0_stall", 32'(o_stall), 0);
    i_sec_valid = 1; i_sec_wra = 0; i_sec_wrd = 32'hBEEF;
    step();
    i_sec_valid = 0;
    step();
    chk_wb("r0_sec", 0, 0, 0);
    chk("r0_empty_rdy", 32'(o_sec_ready), 1);

    // Reset mid-operation flushes FIFO and busy
    i_issue_valid = 1; i_issue_rd = 6;
    i_pri_we = 1; i_pri_wra = 2; i_pri_wrd = 32'h2;
    i_sec_valid = 1; i_sec_wra = 6; i_sec_wrd = 32'h66;
    step();
    i_issue_valid = 0; i_pri_we = 0; i_sec_valid = 0; i_ra1 = 6;
    #1;
    chk("mid_stall", 32'(o_stall), 1);
    rstn = 1'b0;
    step();
    chk("mid_rst_we", 32'(o_regWe), 0);
    chk("mid_rst_rdy", 32'(o_sec_ready), 0);
    rstn = 1'b1;
    #1;
    chk("mid_stall_clr", 32'(o_stall), 0);
    step();
    chk_wb("mid_flushed", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
